// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the CPU top.
// Holds the loader state encoding, the stream byte width and the default
// instruction/address widths so loader and instruction memory agree.
package prog_loader_pkg;

  localparam int BYTE_W      = 8;
  localparam int INSTR_W_DEF = 24;
  localparam int ADDR_W_DEF  = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHK   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  // Number of whole stream bytes needed to carry one instruction.
  function automatic int bytes_per_word(input int width);
    return (width + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/prog_loader_instr_assembler.sv
// Purpose: shifts stream bytes (MSB first) into an instruction word.
// Latency: word_vld_o/word_o are combinational with the final byte of a word.
// Backpressure: none; accepts a byte whenever byte_vld_i is high.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   clear_i           restart assembly at byte 0 (new load)
//   byte_vld_i        a stream byte is being consumed this cycle
//   byte_dat_i        the consumed byte
//   word_vld_o        this byte completes an instruction
//   word_o            the completed instruction (valid with word_vld_o)
module instr_assembler
  import prog_loader_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               byte_vld_i,
  input  logic [BYTE_W-1:0]  byte_dat_i,
  output logic               word_vld_o,
  output logic [INSTR_W-1:0] word_o
);

  localparam int NBYTES = bytes_per_word(INSTR_W);
  localparam int ASM_W  = NBYTES * BYTE_W;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [ASM_W-1:0] asm_q, asm_d, asm_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_byte;

  // Assembly register with the incoming byte already shifted in, so the
  // completed word is available in the same cycle as its last byte.
  assign asm_shift = (asm_q << BYTE_W) | ASM_W'(byte_dat_i);
  assign last_byte = (cnt_q == CNT_W'(NBYTES - 1));

  assign word_vld_o = byte_vld_i && last_byte && !clear_i;
  assign word_o     = asm_shift[INSTR_W-1:0];

  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      asm_d = '0;
      cnt_d = '0;
    end else if (byte_vld_i) begin
      asm_d = asm_shift;
      cnt_d = last_byte ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Purpose: loads a byte stream (count header + MSB-first instruction bytes)
//   into program memory while holding the CPU in reset.
// Latency: mem_we asserts the cycle after the last byte of an instruction.
// Backpressure: rx_ready is a pure function of state; never stalls in DATA.
// Optional: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               begin a load (honoured in IDLE, DONE and ERROR)
//   rx_data/valid/ready byte stream handshake, transfer on valid && ready
//   mem_we/addr/wdata   program memory write port, one strobe per instruction
//   cpu_hold            keeps the CPU in reset while loading or failed
//   done                one-cycle pulse on successful completion
//   error               sticky failure flag, cleared by start
//   loaded              instructions written by the last load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    loaded
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_LOAD = ST_CHK;
`else
  localparam state_e ST_AFTER_LOAD = ST_DONE;
`endif

  state_e             state_q, state_d;
  logic               rx_ready_q, rx_ready_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [INSTR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   loaded_q, loaded_d;
  logic [CNT_W-1:0]   count_q, count_d;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  csum_q, csum_d;
`endif

  logic               rx_fire;
  logic               asm_clear;
  logic               asm_byte_vld;
  logic               word_vld;
  logic [INSTR_W-1:0] word;
  logic [31:0]        hdr_ext;
  logic [CNT_W-1:0]   loaded_inc;

  assign rx_fire      = rx_valid && rx_ready_q;
  assign asm_byte_vld = rx_fire && (state_q == ST_DATA);
  assign hdr_ext      = 32'(rx_data);
  assign loaded_inc   = loaded_q + CNT_W'(1);

  instr_assembler #(
    .INSTR_W (INSTR_W)
  ) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (asm_clear),
    .byte_vld_i (asm_byte_vld),
    .byte_dat_i (rx_data),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    loaded_d    = loaded_q;
    count_d     = count_q;
    asm_clear   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    // Address advances the cycle after each write strobe; with a full
    // DEPTH load it naturally wraps back to 0.
    if (mem_we_q) begin
      mem_addr_d = mem_addr_q + ADDR_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_HDR;
          mem_addr_d = '0;
          loaded_d   = '0;
          asm_clear  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_HDR: begin
        if (rx_fire) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = rx_data;
`endif
          if (rx_data == '0) begin
            state_d = ST_AFTER_LOAD;
          end else if (hdr_ext > 32'(DEPTH)) begin
            state_d = ST_ERROR;
          end else begin
            count_d = CNT_W'(rx_data);
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_fire) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (word_vld) begin
            mem_wdata_d = word;
            loaded_d    = loaded_inc;
            if (loaded_inc == count_q) begin
              state_d = ST_AFTER_LOAD;
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (rx_fire) begin
          state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rx_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CHK);
    cpu_hold_d = rx_ready_d || (state_d == ST_ERROR);
    error_d    = (state_d == ST_ERROR);
    done_d     = (state_d == ST_DONE) && (state_q != ST_DONE);
    mem_we_d   = word_vld;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      loaded_q    <= '0;
      count_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
      loaded_q    <= loaded_d;
      count_q     <= count_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;
  assign loaded    = loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random loads checked against a
// stream-level model of what memory, flags and counters should end up as.
module tb_prog_loader;

  localparam int INSTR_W = 24;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_hold;
  logic               done;
  logic               error;
  logic [ADDR_W:0]    loaded;

  always #5 clk = ~clk;

  prog_loader #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .loaded    (loaded)
  );

  int checks = 0;
  int fails  = 0;

  logic [ADDR_W-1:0]  wr_addr_q[$];
  logic [INSTR_W-1:0] wr_dat_q[$];
  int                 done_total = 0;
  logic [ADDR_W:0]    loaded_at_done = '0;
  int                 hold_drops = 0;
  bit                 loading = 1'b0;
  logic [7:0]         dq[$];
`ifdef LOADER_CHECKSUM_EN
  bit                 chk_bad = 1'b0;
`endif

  // Observe the memory port and status pulses away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_dat_q.push_back(mem_wdata);
    end
    if (done) begin
      done_total     <= done_total + 1;
      loaded_at_done <= loaded;
    end
    if (loading && !cpu_hold) begin
      hold_drops <= hold_drops + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic fill_random(input int nbytes);
    dq.delete();
    for (int i = 0; i < nbytes; i++) dq.push_back(8'($urandom));
  endtask

  // One complete load: start, header, payload from dq (and checksum byte when
  // enabled), then compare the outcome against the stream-level expectation.
  task automatic run_load(input logic [7:0] hdr, input int gap_mode, input bit start_noise);
    int               wb;
    int               db;
    int               n;
    bit               ok;
    bit               exp_done;
    logic [7:0]       x;
    logic [INSTR_W-1:0] w;

    wb = wr_addr_q.size();
    db = done_total;
    ok = (int'(hdr) <= DEPTH);
    n  = ok ? int'(hdr) : 0;

    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    loading = 1'b1;
    @(negedge clk);
    check("hdr_rx_ready", 32'(rx_ready), 32'd1);
    check("hdr_cpu_hold", 32'(cpu_hold), 32'd1);
    check("hdr_error_clr", 32'(error), 32'd0);
    check("hdr_loaded_clr", 32'(loaded), 32'd0);
    @(posedge clk); #1;

    send_byte(hdr, pick_gap(gap_mode));
    x = hdr;
    for (int i = 0; i < n * 3; i++) begin
      if (start_noise && i == 0) start = 1'b1;
      send_byte(dq[i], pick_gap(gap_mode));
      start = 1'b0;
      x = x ^ dq[i];
    end
`ifdef LOADER_CHECKSUM_EN
    if (ok) send_byte(chk_bad ? (x ^ 8'h01) : x, pick_gap(gap_mode));
    exp_done = ok && !chk_bad;
`else
    exp_done = ok;
`endif
    loading = 1'b0;

    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_total - db), exp_done ? 32'd1 : 32'd0);
    check("error_flag", 32'(error), 32'(!exp_done));
    check("cpu_hold_end", 32'(cpu_hold), 32'(!exp_done));
    check("rx_ready_end", 32'(rx_ready), 32'd0);
    check("loaded_end", 32'(loaded), 32'(n));
    check("mem_addr_end", 32'(mem_addr), 32'(n % DEPTH));
    check("hold_during_load", 32'(hold_drops), 32'd0);
    check("write_count", 32'(wr_addr_q.size() - wb), 32'(n));
    if (exp_done) check("loaded_at_done", 32'(loaded_at_done), 32'(n));
    for (int i = 0; i < n && (wb + i) < wr_addr_q.size(); i++) begin
      w = {dq[3*i], dq[3*i+1], dq[3*i+2]};
      check("wr_addr", 32'(wr_addr_q[wb+i]), 32'(i % DEPTH));
      check("wr_data", 32'(wr_dat_q[wb+i]), 32'(w));
    end

    // Bytes offered while rx_ready is low must have no effect.
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h05;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("ignored_no_write", 32'(wr_addr_q.size() - wb), 32'(n));
    check("ignored_no_done", 32'(done_total - db), exp_done ? 32'd1 : 32'd0);
    check("ignored_loaded", 32'(loaded), 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string ph);
    check({ph, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({ph, "_mem_we"}, 32'(mem_we), 32'd0);
    check({ph, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({ph, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({ph, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({ph, "_done"}, 32'(done), 32'd0);
    check({ph, "_error"}, 32'(error), 32'd0);
    check({ph, "_loaded"}, 32'(loaded), 32'd0);
  endtask

  initial begin
    int wb;
    int c;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;

    // Stream bytes in IDLE are not consumed.
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    repeat (2) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("idle_no_write", 32'(wr_addr_q.size()), 32'd0);
    check("idle_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;

    // Two instructions, directed.
    dq = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    run_load(8'h02, 0, 1'b0);
    check("dir_w0", 32'(wr_dat_q[0]), 32'h123456);
    check("dir_w1", 32'(wr_dat_q[1]), 32'hABCDEF);

    // Empty program.
    dq.delete();
    run_load(8'h00, 0, 1'b0);

    // Count larger than memory; the following load restarts from ERROR.
    run_load(8'h21, 0, 1'b0);

    // Full memory with valid toggling every other cycle.
    fill_random(96);
    run_load(8'h20, 1, 1'b0);

    // Random loads, one with start pulsed mid-load, one oversize.
    for (int k = 0; k < 6; k++) begin
      c = int'($urandom_range(1, 32));
      if (k == 3) c = int'($urandom_range(33, 255));
      fill_random((c <= DEPTH) ? c * 3 : 0);
`ifdef LOADER_CHECKSUM_EN
      chk_bad = (k == 1);
`endif
      run_load(8'(c), 2, (k == 2));
    end
`ifdef LOADER_CHECKSUM_EN
    chk_bad = 1'b0;
`endif

    // Reset in the middle of the first instruction.
    wb = wr_addr_q.size();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_no_write", 32'(wr_addr_q.size() - wb), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef LOADER_CHECKSUM_EN
    dq = '{8'h01, 8'h02, 8'h03};
    chk_bad = 1'b0;
    run_load(8'h01, 0, 1'b0);
    chk_bad = 1'b1;
    wb = wr_addr_q.size();
    run_load(8'h01, 0, 1'b0);
    check("chk_bad_w0", 32'(wr_dat_q[wb-1]), 32'h010203);
    chk_bad = 1'b0;
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
